// File: rtl/id_ex_stage.sv
// ID/EX pipeline register with load-use hazard detection, flush squash and
// debug hold. A stall or flush loads an all-zero bubble into the register.
module id_ex_stage #(
  parameter int NB_DATA = 32,
  parameter int NB_REG  = 5
) (
  input  logic               i_clk,
  input  logic               i_reset,
  input  logic               i_enable,
  input  logic               i_flush,
  input  logic [NB_REG-1:0]  i_rs,
  input  logic [NB_REG-1:0]  i_rt,
  input  logic [NB_REG-1:0]  i_rd,
  input  logic [NB_DATA-1:0] i_rs_data,
  input  logic [NB_DATA-1:0] i_rt_data,
  input  logic [NB_DATA-1:0] i_imm,
  input  logic [NB_DATA-1:0] i_pc4,
  input  logic               i_RegWrite,
  input  logic               i_MemRead,
  input  logic               i_MemWrite,
  input  logic               i_MemtoReg,
  input  logic               i_ALUSrc,
  input  logic               i_RegDst,
  input  logic [3:0]         i_ALUOp,
  output logic [NB_REG-1:0]  ID_EX_Rs,
  output logic [NB_REG-1:0]  ID_EX_Rt,
  output logic [NB_REG-1:0]  ID_EX_Rd,
  output logic [NB_DATA-1:0] ID_EX_rs_data,
  output logic [NB_DATA-1:0] ID_EX_rt_data,
  output logic [NB_DATA-1:0] ID_EX_imm,
  output logic [NB_DATA-1:0] ID_EX_pc4,
  output logic               ID_EX_RegWrite,
  output logic               ID_EX_MemRead,
  output logic               ID_EX_MemWrite,
  output logic               ID_EX_MemtoReg,
  output logic               ID_EX_ALUSrc,
  output logic               ID_EX_RegDst,
  output logic [3:0]         ID_EX_ALUOp,
  output logic               o_stall,
  output logic               o_bubble
);

  logic hazard;
  logic load_bubble;

  // A load into $0 never produces a usable value, so it can never stall.
  assign hazard = ID_EX_MemRead && (ID_EX_Rt != '0) &&
                  ((ID_EX_Rt == i_rs) || (ID_EX_Rt == i_rt));

  assign o_stall     = hazard && i_enable && !i_flush;
  assign load_bubble = i_flush || hazard;

  always_ff @(posedge i_clk) begin
    if (i_reset) begin
      ID_EX_Rs       <= '0;
      ID_EX_Rt       <= '0;
      ID_EX_Rd       <= '0;
      ID_EX_rs_data  <= '0;
      ID_EX_rt_data  <= '0;
      ID_EX_imm      <= '0;
      ID_EX_pc4      <= '0;
      ID_EX_RegWrite <= 1'b0;
      ID_EX_MemRead  <= 1'b0;
      ID_EX_MemWrite <= 1'b0;
      ID_EX_MemtoReg <= 1'b0;
      ID_EX_ALUSrc   <= 1'b0;
      ID_EX_RegDst   <= 1'b0;
      ID_EX_ALUOp    <= '0;
      o_bubble       <= 1'b0;
    end else if (i_enable) begin
      if (load_bubble) begin
        ID_EX_Rs       <= '0;
        ID_EX_Rt       <= '0;
        ID_EX_Rd       <= '0;
        ID_EX_rs_data  <= '0;
        ID_EX_rt_data  <= '0;
        ID_EX_imm      <= '0;
        ID_EX_pc4      <= '0;
        ID_EX_RegWrite <= 1'b0;
        ID_EX_MemRead  <= 1'b0;
        ID_EX_MemWrite <= 1'b0;
        ID_EX_MemtoReg <= 1'b0;
        ID_EX_ALUSrc   <= 1'b0;
        ID_EX_RegDst   <= 1'b0;
        ID_EX_ALUOp    <= '0;
        o_bubble       <= 1'b1;
      end else begin
        ID_EX_Rs       <= i_rs;
        ID_EX_Rt       <= i_rt;
        ID_EX_Rd       <= i_rd;
        ID_EX_rs_data  <= i_rs_data;
        ID_EX_rt_data  <= i_rt_data;
        ID_EX_imm      <= i_imm;
        ID_EX_pc4      <= i_pc4;
        ID_EX_RegWrite <= i_RegWrite;
        ID_EX_MemRead  <= i_MemRead;
        ID_EX_MemWrite <= i_MemWrite;
        ID_EX_MemtoReg <= i_MemtoReg;
        ID_EX_ALUSrc   <= i_ALUSrc;
        ID_EX_RegDst   <= i_RegDst;
        ID_EX_ALUOp    <= i_ALUOp;
        o_bubble       <= 1'b0;
      end
    end
  end

endmodule

// File: tb/tb_id_ex_stage.sv
// Bench for id_ex_stage: directed vectors with literal checks, plus a
// per-cycle comparison against a behavioural model of the pipeline register.
module tb_id_ex_stage;

  logic        i_clk = 1'b0;
  logic        i_reset, i_enable, i_flush;
  logic [4:0]  i_rs, i_rt, i_rd;
  logic [31:0] i_rs_data, i_rt_data, i_imm, i_pc4;
  logic [9:0]  ctrl;  // {RegWrite,MemRead,MemWrite,MemtoReg,ALUSrc,RegDst,ALUOp[3:0]}
  logic        i_RegWrite, i_MemRead, i_MemWrite, i_MemtoReg, i_ALUSrc, i_RegDst;
  logic [3:0]  i_ALUOp;

  logic [4:0]  ID_EX_Rs, ID_EX_Rt, ID_EX_Rd;
  logic [31:0] ID_EX_rs_data, ID_EX_rt_data, ID_EX_imm, ID_EX_pc4;
  logic        ID_EX_RegWrite, ID_EX_MemRead, ID_EX_MemWrite, ID_EX_MemtoReg;
  logic        ID_EX_ALUSrc, ID_EX_RegDst;
  logic [3:0]  ID_EX_ALUOp;
  logic        o_stall, o_bubble;

  assign {i_RegWrite, i_MemRead, i_MemWrite, i_MemtoReg, i_ALUSrc, i_RegDst, i_ALUOp} = ctrl;

  localparam logic [9:0] C_ALU  = 10'b1000000010;
  localparam logic [9:0] C_LOAD = 10'b1101110000;

  id_ex_stage #(.NB_DATA(32), .NB_REG(5)) dut (
    .i_clk(i_clk), .i_reset(i_reset), .i_enable(i_enable), .i_flush(i_flush),
    .i_rs(i_rs), .i_rt(i_rt), .i_rd(i_rd),
    .i_rs_data(i_rs_data), .i_rt_data(i_rt_data), .i_imm(i_imm), .i_pc4(i_pc4),
    .i_RegWrite(i_RegWrite), .i_MemRead(i_MemRead), .i_MemWrite(i_MemWrite),
    .i_MemtoReg(i_MemtoReg), .i_ALUSrc(i_ALUSrc), .i_RegDst(i_RegDst), .i_ALUOp(i_ALUOp),
    .ID_EX_Rs(ID_EX_Rs), .ID_EX_Rt(ID_EX_Rt), .ID_EX_Rd(ID_EX_Rd),
    .ID_EX_rs_data(ID_EX_rs_data), .ID_EX_rt_data(ID_EX_rt_data),
    .ID_EX_imm(ID_EX_imm), .ID_EX_pc4(ID_EX_pc4),
    .ID_EX_RegWrite(ID_EX_RegWrite), .ID_EX_MemRead(ID_EX_MemRead),
    .ID_EX_MemWrite(ID_EX_MemWrite), .ID_EX_MemtoReg(ID_EX_MemtoReg),
    .ID_EX_ALUSrc(ID_EX_ALUSrc), .ID_EX_RegDst(ID_EX_RegDst), .ID_EX_ALUOp(ID_EX_ALUOp),
    .o_stall(o_stall), .o_bubble(o_bubble)
  );

  always #5 i_clk = ~i_clk;

  typedef struct packed {
    logic [4:0]  rs, rt, rd;
    logic [31:0] rsd, rtd, imm, pc4;
    logic [9:0]  ctrl;
    logic        bubble;
  } st_t;

  int   total = 0;
  int   bad   = 0;
  st_t  m;
  logic m_valid = 1'b0;

  task automatic chk(input string name, input logic [159:0] act, input logic [159:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s actual=%0h required=%0h", name, act, exp);
    end
  endtask

  function automatic st_t dut_state();
    st_t s;
    s.rs = ID_EX_Rs; s.rt = ID_EX_Rt; s.rd = ID_EX_Rd;
    s.rsd = ID_EX_rs_data; s.rtd = ID_EX_rt_data; s.imm = ID_EX_imm; s.pc4 = ID_EX_pc4;
    s.ctrl = {ID_EX_RegWrite, ID_EX_MemRead, ID_EX_MemWrite, ID_EX_MemtoReg,
              ID_EX_ALUSrc, ID_EX_RegDst, ID_EX_ALUOp};
    s.bubble = o_bubble;
    return s;
  endfunction

  // Model: a pending load to a nonzero register whose result ID wants forces one bubble.
  function automatic logic model_hazard(input st_t s);
    return s.ctrl[8] && (s.rt != 5'd0) && (s.rt == i_rs || s.rt == i_rt);
  endfunction

  always @(negedge i_clk) begin
    st_t nxt;
    if (m_valid) begin
      chk("model_regs", 160'(dut_state()), 160'(m));
      chk("model_stall", 160'(o_stall), 160'(model_hazard(m) && i_enable && !i_flush));
    end
    nxt = m;
    if (i_reset) nxt = '0;
    else if (i_enable) begin
      if (i_flush || model_hazard(m)) begin
        nxt = '0;
        nxt.bubble = 1'b1;
      end else begin
        nxt.rs = i_rs; nxt.rt = i_rt; nxt.rd = i_rd;
        nxt.rsd = i_rs_data; nxt.rtd = i_rt_data; nxt.imm = i_imm; nxt.pc4 = i_pc4;
        nxt.ctrl = ctrl;
        nxt.bubble = 1'b0;
      end
    end
    if (i_reset) m_valid = 1'b1;
    m = nxt;
  end

  task automatic step();
    @(posedge i_clk);
    #1;
  endtask

  task automatic instr(input logic [4:0] rs, input logic [4:0] rt, input logic [4:0] rd,
                       input logic [31:0] rsd, input logic [9:0] c);
    i_rs = rs; i_rt = rt; i_rd = rd;
    i_rs_data = rsd; i_rt_data = rsd ^ 32'hA5A5_0000;
    i_imm = {27'd0, rd} + 32'h100; i_pc4 = {16'h0040, 11'd0, rs} + 32'd4;
    ctrl = c;
    #1;
  endtask

  initial begin
    i_reset = 1'b1; i_enable = 1'b1; i_flush = 1'b1;
    instr(5'd9, 5'd9, 5'd9, 32'hDEAD_BEEF, C_LOAD);
    step(); step();
    chk("reset_regs", 160'(dut_state()), 160'd0);
    chk("reset_stall", 160'(o_stall), 160'd0);

    // Pass-through
    i_reset = 1'b0; i_flush = 1'b0;
    instr(5'd3, 5'd4, 5'd5, 32'h11, 10'b1000000000);
    step();
    chk("pt_rs", 160'(ID_EX_Rs), 160'd3);
    chk("pt_rt", 160'(ID_EX_Rt), 160'd4);
    chk("pt_rd", 160'(ID_EX_Rd), 160'd5);
    chk("pt_rsdata", 160'(ID_EX_rs_data), 160'h11);
    chk("pt_regwrite", 160'(ID_EX_RegWrite), 160'd1);
    chk("pt_stall", 160'(o_stall), 160'd0);

    // Load-use on rs
    instr(5'd1, 5'd5, 5'd0, 32'h22, C_LOAD);
    step();
    instr(5'd5, 5'd6, 5'd7, 32'h33, C_ALU);
    chk("lu_stall", 160'(o_stall), 160'd1);
    step();
    chk("lu_bubble_ctrl", 160'({ID_EX_RegWrite, ID_EX_MemRead, ID_EX_ALUOp}), 160'd0);
    chk("lu_bubble_flag", 160'(o_bubble), 160'd1);
    chk("lu_stall_clear", 160'(o_stall), 160'd0);
    step();
    chk("lu_capture_rs", 160'(ID_EX_Rs), 160'd5);
    chk("lu_capture_bubble", 160'(o_bubble), 160'd0);

    // Load-use on rt
    instr(5'd2, 5'd9, 5'd0, 32'h44, C_LOAD);
    step();
    instr(5'd1, 5'd9, 5'd3, 32'h55, C_ALU);
    chk("lu_rt_stall", 160'(o_stall), 160'd1);
    step(); step();

    // Load to $0
    instr(5'd2, 5'd0, 5'd0, 32'h66, C_LOAD);
    step();
    instr(5'd0, 5'd0, 5'd8, 32'h77, C_ALU);
    chk("z0_stall", 160'(o_stall), 160'd0);
    step();
    chk("z0_capture_rsdata", 160'(ID_EX_rs_data), 160'h77);

    // Flush during hazard
    instr(5'd1, 5'd7, 5'd0, 32'h88, C_LOAD);
    step();
    instr(5'd7, 5'd2, 5'd4, 32'h99, C_ALU);
    i_flush = 1'b1; #1;
    chk("fl_stall", 160'(o_stall), 160'd0);
    step();
    i_flush = 1'b0;
    chk("fl_bubble", 160'(o_bubble), 160'd1);

    // Debug hold with a hazard pending
    instr(5'd1, 5'd8, 5'd0, 32'hAA, C_LOAD);
    step();
    i_enable = 1'b0;
    for (int k = 0; k < 3; k++) begin
      instr(5'd8, 5'(k + 10), 5'(k), 32'(k) + 32'hB0, C_ALU);
      chk("hold_stall", 160'(o_stall), 160'd0);
      step();
      chk("hold_rt", 160'(ID_EX_Rt), 160'd8);
    end

    // Reset mid-stall
    i_enable = 1'b1; #1;
    chk("rst_pre_stall", 160'(o_stall), 160'd1);
    i_reset = 1'b1;
    #2;
    chk("rst_pre_edge_rt", 160'(ID_EX_Rt), 160'd8);
    step();
    chk("rst_regs", 160'(dut_state()), 160'd0);
    chk("rst_stall", 160'(o_stall), 160'd0);
    i_reset = 1'b0;
    step();
    chk("rst_no_bubble", 160'(o_bubble), 160'd0);
    chk("rst_capture_rs", 160'(ID_EX_Rs), 160'd8);

    // Pseudo-random tail, checked only by the model
    for (int k = 0; k < 60; k++) begin
      i_enable = ($urandom_range(0, 7) != 0);
      i_flush  = ($urandom_range(0, 7) == 0);
      i_reset  = ($urandom_range(0, 31) == 0);
      instr(5'($urandom_range(0, 3)), 5'($urandom_range(0, 3)), 5'($urandom_range(0, 31)),
            $urandom, (($urandom_range(0, 2) == 0) ? C_LOAD : 10'($urandom)));
      step();
    end

    @(negedge i_clk);
    #1;
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL timeout actual=running required=finished");
    $fatal(1);
  end

endmodule

// File: doc/id_ex_stage.md
ID_EX_STAGE -- requirements
Module: id_ex_stage

Interface
REQ-001 SHALL have parameter NB_DATA, default 32, data/immediate/PC width.
REQ-002 SHALL have parameter NB_REG, default 5, register-specifier width.
REQ-003 SHALL have ports i_clk input 1 (system clock) and i_reset input 1 (synchronous, active-high), listed first.
REQ-004 SHALL have i_enable input 1: pipeline advance enable from the debug unit.
REQ-005 SHALL have i_flush input 1: branch-taken squash of the instruction in ID.
REQ-006 SHALL have i_rs, i_rt, i_rd, each input NB_REG: register specifiers of the instruction in ID.
REQ-007 SHALL have i_rs_data, i_rt_data, i_imm, i_pc4, each input NB_DATA: operand data, sign-extended immediate and PC+4 from ID.
REQ-008 SHALL have control inputs i_RegWrite, i_MemRead, i_MemWrite, i_MemtoReg, i_ALUSrc, i_RegDst, each 1 bit, and i_ALUOp input 4.
REQ-009 SHALL have registered outputs ID_EX_Rs, ID_EX_Rt, ID_EX_Rd (NB_REG), ID_EX_rs_data, ID_EX_rt_data, ID_EX_imm, ID_EX_pc4 (NB_DATA), and ID_EX_ copies of every control input at the same width.
REQ-010 SHALL have o_stall output 1: load-use hazard, holds PC and IF/ID.
REQ-011 SHALL have o_bubble output 1: asserted in the cycle after a bubble or flush was loaded.

Function
REQ-012 SHALL compute hazard = ID_EX_MemRead & (ID_EX_Rt != 0) & ((ID_EX_Rt == i_rs) | (ID_EX_Rt == i_rt)), combinationally from the current register contents and ID inputs.
REQ-013 SHALL drive o_stall = hazard & i_enable & ~i_flush, with zero latency in the same cycle.
REQ-014 SHALL, on a rising edge with i_enable=0, hold all registers, including o_bubble.
REQ-015 SHALL, on a rising edge with i_enable=1 and i_flush=1, load a bubble and set o_bubble=1; flush has priority over the hazard.
REQ-016 SHALL, on a rising edge with i_enable=1, i_flush=0 and hazard=1, load a bubble and set o_bubble=1.
REQ-017 SHALL, on a rising edge with i_enable=1, i_flush=0 and hazard=0, capture all ID inputs unchanged and set o_bubble=0.
REQ-018 SHALL define a bubble as all control outputs 0 and all register-specifier, data, immediate and PC outputs 0.
REQ-019 SHALL insert exactly one bubble per load-use: after the bubble, ID_EX_MemRead=0, so hazard deasserts and the held instruction advances on the next enabled edge.
REQ-020 SHALL never stall when the load targets register 0, including when i_rs or i_rt is 0.
REQ-021 SHALL make a single-cycle capture latency: ID inputs at edge N appear on ID_EX_ outputs after edge N.
REQ-022 SHALL produce no combinational path from the ID inputs to any ID_EX_ output.

Reset
REQ-023 SHALL, on i_reset=1 at a rising edge, clear every ID_EX_ output and o_bubble to 0, regardless of i_enable or i_flush.
REQ-024 SHALL give reset priority over flush, stall and enable.
REQ-025 SHALL keep o_stall at 0 while registers hold reset values, since ID_EX_MemRead=0.
REQ-026 SHALL treat reset asserted mid-stall as discarding the pending load; no bubble follows release.

Verification
REQ-027 SHALL cover pass-through: enable=1, i_rs=3, i_rt=4, i_rd=5, i_rs_data=0x11, RegWrite=1 -> next cycle ID_EX_Rs=3, ID_EX_Rt=4, ID_EX_Rd=5, ID_EX_rs_data=0x11, ID_EX_RegWrite=1, o_stall=0.
REQ-028 SHALL cover load-use: ID_EX_MemRead=1, ID_EX_Rt=5, then i_rs=5 -> o_stall=1 same cycle; next edge all controls=0 and o_bubble=1; following cycle o_stall=0 and the instruction with i_rs=5 captured.
REQ-029 SHALL cover load to $0: ID_EX_MemRead=1, ID_EX_Rt=0, i_rs=0 -> o_stall=0 and normal capture.
REQ-030 SHALL cover flush during hazard: hazard conditions plus i_flush=1 -> o_stall=0; next edge bubble loaded and o_bubble=1.
REQ-031 SHALL cover debug hold: i_enable=0 for 3 edges while ID inputs change -> outputs unchanged; with hazard present, o_stall=0.
REQ-032 SHALL cover synchronous reset: i_reset=1 while ID_EX_MemRead=1 and stalling -> after the edge all outputs 0 and o_stall=0; no output change before the edge.
